// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 definitions used by the EX-stage units.
// Contents: XLEN, the mulctl op encodings (func3[1:0]), and the multiply FSM states.
package riscv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      MUL_LO  = 2'b00,
      MULH_SS = 2'b01,
      MULH_SU = 2'b10,
      MULH_UU = 2'b11
   } mulctl_e;

   typedef enum logic [1:0] {
      MS_IDLE = 2'b00,
      MS_CALC = 2'b01,
      MS_HOLD = 2'b10
   } mul_state_e;

endpackage

// File: rtl/mul_operand_cond.sv
// mul_operand_cond: combinational sign/magnitude extraction for the multiply operands.
// Ports: mulctl_i (op select), a_i/b_i (rs1/rs2) -> a_mag_o/b_mag_o (|a|,|b|), neg_o (product sign).
module mul_operand_cond
   import riscv_pkg::*;
(
   input  logic [1:0]      mulctl_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] a_mag_o,
   output logic [XLEN-1:0] b_mag_o,
   output logic            neg_o
);

   logic a_sgn;
   logic b_sgn;

   // An operand only counts as negative when the op treats it as signed.
   always_comb begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      case (mulctl_e'(mulctl_i))
         MUL_LO, MULH_SS: begin
            a_sgn = a_i[XLEN-1];
            b_sgn = b_i[XLEN-1];
         end
         MULH_SU: a_sgn = a_i[XLEN-1];
         default: ;
      endcase
   end

   // 0x80000000 negates to itself, which read unsigned is 2^31.
   assign a_mag_o = a_sgn ? -a_i : a_i;
   assign b_mag_o = b_sgn ? -b_i : b_i;
   assign neg_o   = a_sgn ^ b_sgn;

endmodule

// File: rtl/mul_unit.sv
// mul_unit: iterative radix-2 shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// Ports: clk_i, rst_ni (sync, active-low), mulstart_i (level request), mulctl_i, a_i, b_i;
//        busy_o (in CALC), done_o (1-cycle pulse on entering HOLD), result_o (registered).
// Option: define MUL_EARLY_OUT_EN to leave CALC as soon as the multiplier register is zero.
module mul_unit
   import riscv_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            mulstart_i,
   input  logic [1:0]      mulctl_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   mul_state_e        state_q, state_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [2*XLEN-1:0] mcand_q, mcand_d;
   logic [XLEN-1:0]   mplier_q, mplier_d;
   logic [5:0]        cnt_q, cnt_d;
   logic              neg_q, neg_d;
   mulctl_e           ctl_q, ctl_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              done_q, done_d;

   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;
   logic              neg;
   logic              calc_last;
   logic [2*XLEN-1:0] prod;

   mul_operand_cond u_cond (
      .mulctl_i (mulctl_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .a_mag_o  (a_mag),
      .b_mag_o  (b_mag),
      .neg_o    (neg)
   );

   // Default build spends one extra CALC edge after the 32nd iteration
   // to apply the sign and register the result.
`ifdef MUL_EARLY_OUT_EN
   assign calc_last = (mplier_q == '0);
`else
   assign calc_last = (cnt_q == 6'd32);
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= MS_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         ctl_q    <= MUL_LO;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         ctl_q    <= ctl_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         MS_IDLE: if (mulstart_i) state_d = MS_CALC;
         MS_CALC: if (calc_last) state_d = MS_HOLD;
         MS_HOLD: if (!mulstart_i) state_d = MS_IDLE;
         default: state_d = MS_IDLE;
      endcase
   end

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      ctl_d    = ctl_q;
      result_d = result_q;
      done_d   = 1'b0;
      prod     = neg_q ? -acc_q : acc_q;
      case (state_q)
         MS_IDLE: begin
            if (mulstart_i) begin
               acc_d    = '0;
               mcand_d  = {{XLEN{1'b0}}, a_mag};
               mplier_d = b_mag;
               cnt_d    = '0;
               neg_d    = neg;
               ctl_d    = mulctl_e'(mulctl_i);
            end
         end
         MS_CALC: begin
            if (calc_last) begin
               result_d = (ctl_q == MUL_LO) ? prod[XLEN-1:0]
                                            : prod[2*XLEN-1:XLEN];
               done_d   = 1'b1;
            end else begin
               if (mplier_q[0]) acc_d = acc_q + mcand_q;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + 6'd1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy_o   = (state_q == MS_CALC);
      done_o   = done_q;
      result_o = result_q;
   end

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: table-driven and random checks of mul_unit with a result scoreboard.
// Builds with or without MUL_EARLY_OUT_EN; expected latency follows the build.
module tb_mul_unit;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mulstart;
   logic [1:0]  mulctl;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        busy;
   logic        done;
   logic [31:0] result;

   always #5 clk = ~clk;

   mul_unit dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .mulstart_i (mulstart),
      .mulctl_i   (mulctl),
      .a_i        (a_in),
      .b_i        (b_in),
      .busy_o     (busy),
      .done_o     (done),
      .result_o   (result)
   );

   typedef struct {
      logic [1:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t        tab[12];
   logic [31:0] sb_q[$];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model(input logic [1:0] c,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = (c != 2'b11 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
      eb = (c <= 2'b01 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
      p  = ea * eb;
      return (c == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   function automatic int lat_of(input logic [1:0] c, input logic [31:0] b);
`ifdef MUL_EARLY_OUT_EN
      logic [31:0] mag;
      mag = (c <= 2'b01 && b[31]) ? (32'd0 - b) : b;
      for (int i = 31; i >= 0; i--)
         if (mag[i]) return i + 2;
      return 1;
`else
      return 33;
`endif
   endfunction

   task automatic run_op(input logic [1:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int hold, input bit drop_early);
      int          lat;
      int          k;
      logic [31:0] r;
      lat = lat_of(c, b);
      mulctl   = c;
      a_in     = a;
      b_in     = b;
      mulstart = 1'b1;
      sb_q.push_back(exp);
      tick();
      chk("busy_e0", {31'b0, busy}, 32'd1);
      mulctl = ~c;
      a_in   = $urandom;
      b_in   = $urandom;
      if (drop_early) mulstart = 1'b0;
      k = 0;
      while (!done && k < 40) begin
         tick();
         k++;
         if (!done) chk("busy_calc", {31'b0, busy}, 32'd1);
      end
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: got no done in %0d edges want %0d", k, lat);
         r = sb_q.pop_front();
         mulstart = 1'b0;
         tick();
         return;
      end
      chk("latency", k, lat);
      chk("busy_hold", {31'b0, busy}, 32'd0);
      r = sb_q.pop_front();
      chk("result", result, r);
      for (int h = 0; h < hold; h++) begin
         tick();
         chk("done_pulse", {31'b0, done}, 32'd0);
         chk("hold_stable", result, r);
      end
      mulstart = 1'b0;
      tick();
      chk("idle_done", {31'b0, done}, 32'd0);
      chk("idle_busy", {31'b0, busy}, 32'd0);
      chk("idle_result", result, r);
   endtask

   initial begin
      bit saw;
      tab[0]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
      tab[1]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      tab[2]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      tab[3]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      tab[4]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
      tab[5]  = '{2'b00, 32'h1234_5678, 32'h0000_0001, 32'h1234_5678};
      tab[6]  = '{2'b11, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
      tab[7]  = '{2'b11, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001};
      tab[8]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF};
      tab[9]  = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
      tab[10] = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000};
      tab[11] = '{2'b00, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000};

      rst_n    = 1'b0;
      mulstart = 1'b0;
      mulctl   = 2'b00;
      a_in     = '0;
      b_in     = '0;
      tick();
      tick();
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 12; i++)
         run_op(tab[i].c, tab[i].a, tab[i].b, tab[i].exp, 0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         logic [1:0]  c;
         logic [31:0] a, b;
         c = 2'($urandom_range(3));
         a = $urandom;
         b = (i < 4) ? ($urandom >> $urandom_range(31)) : $urandom;
         run_op(c, a, b, model(c, a, b), 0, 1'b0);
      end

      // start held past done, then an immediate re-accept
      run_op(2'b00, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5, 1'b0);
      run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1'b0);
      // start dropped mid-calc; the op still completes
      run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 1'b1);

      // reset at iteration 10 of a MULH
      mulctl   = 2'b01;
      a_in     = 32'h1234_5678;
      b_in     = 32'h9ABC_DEF0;
      mulstart = 1'b1;
      tick();
      repeat (10) tick();
      rst_n = 1'b0;
      tick();
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_done", {31'b0, done}, 32'd0);
      chk("midrst_result", result, 32'd0);
      mulstart = 1'b0;
      rst_n    = 1'b1;
      saw      = 1'b0;
      repeat (40) begin
         tick();
         if (done) saw = 1'b1;
      end
      chk("no_done_after_rst", {31'b0, saw}, 32'd0);
      run_op(2'b00, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative RV32M multiply unit in the EX stage, downstream of the main controller. It consumes the controller's `mulstart`/`mulctl` and the two register operands. It computes MUL/MULH/MULHSU/MULHU with a radix-2 shift-add datapath and returns the 32-bit result with a `done` pulse that drives the controller's `exdone`. It holds its result stable until the controller drops `mulstart`, so a level-held start never re-triggers.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset is synchronous and active-low.
- `mulstart`  in  1  level request from controller; high for the whole M-type instruction.
- `mulctl`  in  2  op select: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (equals func3[1:0]).
- `a`  in  XLEN  rs1 value.
- `b`  in  XLEN  rs2 value.
- `busy`  out  1  high in CALC.
- `done`  out  1  one-cycle pulse on entry to HOLD; wired to controller `exdone`.
- `result`  out  XLEN  registered result; valid from `done` until next accept or reset.

## Operation
- States: IDLE, CALC, HOLD.
- **IDLE:**
  - `mulstart=1` → accept: latch `mulctl` and operand signs, load magnitudes, go to CALC.
  - Sign rules: `a` is signed for MUL/MULH/MULHSU. `b` is signed for MUL/MULH. Otherwise the operand is unsigned.
  - Magnitude of a negative value is its two's-complement negation, taken as 32-bit unsigned. 0x80000000 → 2^31.
  - `neg` = sign(a) XOR sign(b), using the signedness above.
- **CALC:**
  - Datapath: 64-bit accumulator, 64-bit multiplicand register (shifted left 1 per iteration), 32-bit multiplier register (shifted right 1 per iteration), 6-bit iteration counter.
  - Each edge: if multiplier[0], add multiplicand to accumulator; then shift both registers; counter++.
  - After iteration 31 completes, go to HOLD.
- **HOLD entry:**
  - product = neg ? −acc : acc (64-bit two's complement).
  - `result` = product[31:0] for MUL, else product[63:32].
  - `done`=1 for exactly one cycle.
- **HOLD:** stay while `mulstart=1`; `mulstart=0` → IDLE.
- `a`, `b` and `mulctl` are ignored outside the accepting edge.
- Reset (`rst_n=0` at an edge, any state including mid-CALC): state IDLE, `busy`=0, `done`=0, `result`=0, counter and datapath registers 0. The in-flight operation is abandoned without a `done`.

## Timing
- Accept edge E0 (IDLE, `mulstart=1`) → `busy`=1 from E0 to E32.
- E33 enters HOLD: `done`=1 and `result` valid in the cycle after E33. Fixed latency is 33 edges without the early-out feature.
- `done` deasserts at E34 regardless of `mulstart`.
- `mulstart` low before HOLD has no effect; the operation completes.
- Earliest re-accept: the edge after the HOLD→IDLE edge, i.e. one IDLE cycle is always present between operations.

## Configuration
- `MUL_EARLY_OUT_EN` defined:
  - In CALC, if the multiplier register is 0 at an edge, go to HOLD at that edge instead of iterating.
  - Latency is 1 + (index of the highest set bit of |b|) + 1 edges: b=0 → 1 edge, b=1 → 2 edges, worst case 33.
- `MUL_EARLY_OUT_EN` undefined: always 33 edges.
- Results are identical in both builds.

## Structure
- Shared package `riscv_pkg` holds:
  - `mulctl` encodings: MUL_LO, MULH_SS, MULH_SU, MULH_UU.
  - FSM state encoding.
  - XLEN.
- The controller's EX decoder imports the same `mulctl` constants.
- One sub-module, `mul_operand_cond`: combinational sign and magnitude extraction for both operands plus the `neg` flag, used at accept.

## Test plan
- MUL, a=7, b=0xFFFFFFFD, `mulstart` held → `result`=0xFFFFFFEB, `done` one cycle after E33, `busy` high E0–E32.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF. MUL of the same operands → 0x00000001.
- `mulstart` held high 5 cycles past `done`, then low → exactly one `done` pulse, `result` stable throughout, IDLE next, re-accept works on the following edge.
- `rst_n` low at iteration 10 of a MULH → next cycle `busy`=0, `done`=0, `result`=0, and no `done` afterwards.
- With `MUL_EARLY_OUT_EN`:
  - b=0 → `done` after 1 edge, `result`=0.
  - b=1, a=0x12345678, MUL → 2 edges, 0x12345678.
  - b=0x80000000, MULHU → 33 edges.
